alu_seq_unit: RTL and testbench

Parametrised, clocked successor to the 8085 accumulator/ALU datapath. Holds the accumulator, operand latches (ACT/TMP) and a 5-bit flag register, and executes one ALU operation per handshake. Adds what the single-width combinational datapath lacks: a generic WIDTH, a valid/ready command port, a registered result, BCD adjust (DAA), and a two-pass double-width add (DAD) with carry chaining. Sits between the instruction decoder/sequencer and the internal data bus.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_core.sv | 102 ++++++++++
 rtl/alu_seq_unit.sv | 169 ++++++++++++++++
 tb/tb_alu_seq_unit.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the sequenced accumulator/ALU unit.
// Op encoding, flag bit positions, BCD digit width and FSM states.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,  OP_ADC = 4'd1,  OP_SUB = 4'd2,  OP_SBB = 4'd3,
    OP_ANA = 4'd4,  OP_XRA = 4'd5,  OP_ORA = 4'd6,  OP_CMP = 4'd7,
    OP_RLC = 4'd8,  OP_RRC = 4'd9,  OP_RAL = 4'd10, OP_RAR = 4'd11,
    OP_DAA = 4'd12, OP_CMA = 4'd13, OP_STC = 4'd14, OP_DAD = 4'd15
  } alu_op_t;

  localparam int FLG_S  = 4;
  localparam int FLG_Z  = 3;
  localparam int FLG_AC = 2;
  localparam int FLG_P  = 1;
  localparam int FLG_CY = 0;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXEC    = 2'd1,
    ST_EXEC_LO = 2'd2,
    ST_EXEC_HI = 2'd3
  } seq_state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational WIDTH-bit adder/logic/rotate/decimal-adjust core.
// carry_out is already a borrow for subtract ops; aux_carry is the digit-0 carry.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  alu_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             aux_in,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             aux_carry
);

  localparam int NDIG = WIDTH / DIGIT_W;
  localparam logic [DIGIT_W:0] DEC_MAX = (DIGIT_W + 1)'(9);
  localparam logic [DIGIT_W:0] DEC_FIX = (DIGIT_W + 1)'(6);

  logic               is_sub;
  logic               add_cin;
  logic [WIDTH-1:0]   b_eff;
  logic [WIDTH:0]     sum;
  logic [DIGIT_W:0]   nib_sum;
  logic [NDIG:0]      dcarry;
  logic [WIDTH-1:0]   daa_res;

  always_comb begin
    is_sub  = (op == OP_SUB) || (op == OP_SBB) || (op == OP_CMP);
    b_eff   = is_sub ? ~b : b;
    case (op)
      OP_ADC:         add_cin = carry_in;
      OP_SUB, OP_CMP: add_cin = 1'b1;
      OP_SBB:         add_cin = ~carry_in;
      default:        add_cin = 1'b0;
    endcase
    sum     = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, add_cin};
    nib_sum = {1'b0, a[DIGIT_W-1:0]} + {1'b0, b_eff[DIGIT_W-1:0]} + {{DIGIT_W{1'b0}}, add_cin};
  end

  // Decimal adjust: each digit absorbs the carry from below before its own >9 test.
  assign dcarry[0] = 1'b0;
  for (genvar gi = 0; gi < NDIG; gi++) begin : g_daa
    logic [DIGIT_W:0] raw;
    logic [DIGIT_W:0] adj;
    logic             fix;
    assign raw = {1'b0, a[gi*DIGIT_W +: DIGIT_W]} + {{DIGIT_W{1'b0}}, dcarry[gi]};
    assign fix = (raw > DEC_MAX) || ((gi == 0) && aux_in) || ((gi == NDIG - 1) && carry_in);
    assign adj = raw + (fix ? DEC_FIX : '0);
    assign daa_res[gi*DIGIT_W +: DIGIT_W] = adj[DIGIT_W-1:0];
    assign dcarry[gi+1] = adj[DIGIT_W];
  end

  always_comb begin
    result    = sum[WIDTH-1:0];
    carry_out = 1'b0;
    aux_carry = 1'b0;
    case (op)
      OP_ADD, OP_ADC, OP_SUB, OP_SBB, OP_CMP, OP_DAD: begin
        result    = sum[WIDTH-1:0];
        carry_out = is_sub ? ~sum[WIDTH] : sum[WIDTH];
        aux_carry = nib_sum[DIGIT_W];
      end
      OP_ANA: begin
        result    = a & b;
        aux_carry = a[DIGIT_W-1] | b[DIGIT_W-1];
      end
      OP_XRA: result = a ^ b;
      OP_ORA: result = a | b;
      OP_RLC: begin
        result    = {a[WIDTH-2:0], a[WIDTH-1]};
        carry_out = a[WIDTH-1];
      end
      OP_RRC: begin
        result    = {a[0], a[WIDTH-1:1]};
        carry_out = a[0];
      end
      OP_RAL: begin
        result    = {a[WIDTH-2:0], carry_in};
        carry_out = a[WIDTH-1];
      end
      OP_RAR: begin
        result    = {carry_in, a[WIDTH-1:1]};
        carry_out = a[0];
      end
      OP_DAA: begin
        result    = daa_res;
        carry_out = dcarry[NDIG] | carry_in;
        aux_carry = dcarry[1];
      end
      OP_CMA: result = ~a;
      OP_STC: begin
        result    = a;
        carry_out = 1'b1;
      end
      default: result = sum[WIDTH-1:0];
    endcase
  end

endmodule

// File: rtl/alu_seq_unit.sv
// Clocked accumulator/ALU: one op per valid/ready handshake, registered results,
// and a two-pass double-width add that reuses the single core.
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               phi2,
  input  logic               rst,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [3:0]         op_code,
  input  logic [WIDTH-1:0]   op_tmp,
  input  logic [2*WIDTH-1:0] pair_a,
  input  logic [2*WIDTH-1:0] pair_b,
  input  logic               acc_wr,
  input  logic [WIDTH-1:0]   acc_wdata,
  output logic [WIDTH-1:0]   acc,
  output logic [4:0]         flags,
  output logic               res_valid,
  output logic [2*WIDTH-1:0] res_pair
);

  seq_state_t         state_reg, state_next;
  alu_op_t            op_reg, op_next;
  logic [WIDTH-1:0]   act_reg, act_next;
  logic [WIDTH-1:0]   tmp_reg, tmp_next;
  logic [2*WIDTH-1:0] pa_reg, pa_next;
  logic [2*WIDTH-1:0] pb_reg, pb_next;
  logic [WIDTH-1:0]   dad_lo_reg, dad_lo_next;
  logic               dad_cy_reg, dad_cy_next;
  logic [WIDTH-1:0]   acc_reg, acc_next;
  logic [4:0]         flags_reg, flags_next;
  logic               res_valid_reg, res_valid_next;
  logic [2*WIDTH-1:0] res_pair_reg, res_pair_next;

  alu_op_t            core_op;
  logic [WIDTH-1:0]   core_a, core_b, core_res;
  logic               core_cin, core_aux, core_co, core_ac;

  // Operand steering: DAD passes take pair halves, everything else uses ACT/TMP.
  always_comb begin
    core_op  = op_reg;
    core_a   = act_reg;
    core_b   = tmp_reg;
    core_cin = flags_reg[FLG_CY];
    core_aux = flags_reg[FLG_AC];
    if (state_reg == ST_EXEC_LO) begin
      core_op  = OP_ADD;
      core_a   = pa_reg[WIDTH-1:0];
      core_b   = pb_reg[WIDTH-1:0];
      core_cin = 1'b0;
    end else if (state_reg == ST_EXEC_HI) begin
      core_op  = OP_ADC;
      core_a   = pa_reg[2*WIDTH-1:WIDTH];
      core_b   = pb_reg[2*WIDTH-1:WIDTH];
      core_cin = dad_cy_reg;
    end
  end

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op        (core_op),
    .a         (core_a),
    .b         (core_b),
    .carry_in  (core_cin),
    .aux_in    (core_aux),
    .result    (core_res),
    .carry_out (core_co),
    .aux_carry (core_ac)
  );

  always_comb begin
    state_next     = state_reg;
    op_next        = op_reg;
    act_next       = act_reg;
    tmp_next       = tmp_reg;
    pa_next        = pa_reg;
    pb_next        = pb_reg;
    dad_lo_next    = dad_lo_reg;
    dad_cy_next    = dad_cy_reg;
    acc_next       = acc_reg;
    flags_next     = flags_reg;
    res_valid_next = 1'b0;
    res_pair_next  = res_pair_reg;
    case (state_reg)
      ST_IDLE: begin
        if (acc_wr) acc_next = acc_wdata;
        if (op_valid) begin
          act_next   = acc_wr ? acc_wdata : acc_reg;
          tmp_next   = op_tmp;
          op_next    = alu_op_t'(op_code);
          pa_next    = pair_a;
          pb_next    = pair_b;
          state_next = (alu_op_t'(op_code) == OP_DAD) ? ST_EXEC_LO : ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_next     = ST_IDLE;
        res_valid_next = 1'b1;
        case (op_reg)
          OP_ADD, OP_ADC, OP_SUB, OP_SBB, OP_ANA, OP_XRA, OP_ORA, OP_CMP, OP_DAA: begin
            if (op_reg != OP_CMP) acc_next = core_res;
            flags_next[FLG_S]  = core_res[WIDTH-1];
            flags_next[FLG_Z]  = (core_res == '0);
            flags_next[FLG_AC] = core_ac;
            flags_next[FLG_P]  = ~^core_res;
            flags_next[FLG_CY] = core_co;
          end
          OP_RLC, OP_RRC, OP_RAL, OP_RAR: begin
            acc_next           = core_res;
            flags_next[FLG_CY] = core_co;
          end
          OP_CMA:  acc_next = core_res;
          OP_STC:  flags_next[FLG_CY] = 1'b1;
          default: ;
        endcase
      end
      ST_EXEC_LO: begin
        dad_lo_next = core_res;
        dad_cy_next = core_co;
        state_next  = ST_EXEC_HI;
      end
      ST_EXEC_HI: begin
        res_pair_next      = {core_res, dad_lo_reg};
        flags_next[FLG_CY] = core_co;
        res_valid_next     = 1'b1;
        state_next         = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge phi2 or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      op_reg        <= OP_ADD;
      act_reg       <= '0;
      tmp_reg       <= '0;
      pa_reg        <= '0;
      pb_reg        <= '0;
      dad_lo_reg    <= '0;
      dad_cy_reg    <= 1'b0;
      acc_reg       <= '0;
      flags_reg     <= '0;
      res_valid_reg <= 1'b0;
      res_pair_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      op_reg        <= op_next;
      act_reg       <= act_next;
      tmp_reg       <= tmp_next;
      pa_reg        <= pa_next;
      pb_reg        <= pb_next;
      dad_lo_reg    <= dad_lo_next;
      dad_cy_reg    <= dad_cy_next;
      acc_reg       <= acc_next;
      flags_reg     <= flags_next;
      res_valid_reg <= res_valid_next;
      res_pair_reg  <= res_pair_next;
    end
  end

  assign op_ready  = (state_reg == ST_IDLE);
  assign acc       = acc_reg;
  assign flags     = flags_reg;
  assign res_valid = res_valid_reg;
  assign res_pair  = res_pair_reg;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit: an 8-bit and a 16-bit instance driven with
// hand-computed vectors; flags are shown as {S,Z,AC,P,CY}.
module tb_alu_seq_unit;
  import alu_pkg::*;

  logic phi2 = 1'b0;
  logic rst  = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 phi2 = ~phi2;

  logic        d8_op_valid = 1'b0, d8_op_ready, d8_acc_wr = 1'b0, d8_res_valid;
  logic [3:0]  d8_op_code = 4'd0;
  logic [7:0]  d8_op_tmp = '0, d8_acc_wdata = '0, d8_acc;
  logic [15:0] d8_pair_a = '0, d8_pair_b = '0, d8_res_pair;
  logic [4:0]  d8_flags;

  logic        d16_op_valid = 1'b0, d16_op_ready, d16_acc_wr = 1'b0, d16_res_valid;
  logic [3:0]  d16_op_code = 4'd0;
  logic [15:0] d16_op_tmp = '0, d16_acc_wdata = '0, d16_acc;
  logic [31:0] d16_pair_a = '0, d16_pair_b = '0, d16_res_pair;
  logic [4:0]  d16_flags;

  alu_seq_unit #(.WIDTH(8)) dut8 (
    .phi2(phi2), .rst(rst), .op_valid(d8_op_valid), .op_ready(d8_op_ready),
    .op_code(d8_op_code), .op_tmp(d8_op_tmp), .pair_a(d8_pair_a), .pair_b(d8_pair_b),
    .acc_wr(d8_acc_wr), .acc_wdata(d8_acc_wdata), .acc(d8_acc), .flags(d8_flags),
    .res_valid(d8_res_valid), .res_pair(d8_res_pair)
  );

  alu_seq_unit #(.WIDTH(16)) dut16 (
    .phi2(phi2), .rst(rst), .op_valid(d16_op_valid), .op_ready(d16_op_ready),
    .op_code(d16_op_code), .op_tmp(d16_op_tmp), .pair_a(d16_pair_a), .pair_b(d16_pair_b),
    .acc_wr(d16_acc_wr), .acc_wdata(d16_acc_wdata), .acc(d16_acc), .flags(d16_flags),
    .res_valid(d16_res_valid), .res_pair(d16_res_pair)
  );

  task automatic step();
    @(posedge phi2);
    #1;
  endtask

  task automatic load8(input logic [7:0] v);
    d8_acc_wr = 1'b1; d8_acc_wdata = v;
    step();
    d8_acc_wr = 1'b0;
  endtask

  task automatic issue8(input logic [3:0] op, input logic [7:0] t);
    d8_op_valid = 1'b1; d8_op_code = op; d8_op_tmp = t;
    step();
    d8_op_valid = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if ({d8_op_ready, d8_res_valid, d8_acc, d8_flags, d8_res_pair} !== {1'b1, 1'b0, 8'h00, 5'h00, 16'h0000}) begin
      n_bad++;
      $display("FAIL reset8: got rdy/rv/acc/flg/pair=%b/%b/%h/%h/%h want 1/0/00/00/0000",
               d8_op_ready, d8_res_valid, d8_acc, d8_flags, d8_res_pair);
    end
    n_cmp++;
    if ({d16_op_ready, d16_res_valid, d16_acc, d16_flags} !== {1'b1, 1'b0, 16'h0000, 5'h00}) begin
      n_bad++;
      $display("FAIL reset16: got rdy/rv/acc/flg=%b/%b/%h/%h want 1/0/0000/00",
               d16_op_ready, d16_res_valid, d16_acc, d16_flags);
    end
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_add();
    load8(8'h3A);
    issue8(OP_ADD, 8'hC6);
    n_cmp++;
    if ({d8_op_ready, d8_res_valid} !== 2'b00) begin
      n_bad++;
      $display("FAIL add_busy: got rdy/rv=%b%b want 00", d8_op_ready, d8_res_valid);
    end
    step();
    n_cmp++;
    if ({d8_res_valid, d8_op_ready, d8_acc, d8_flags} !== {1'b1, 1'b1, 8'h00, 5'h0F}) begin
      n_bad++;
      $display("FAIL add_result: got rv/rdy/acc/flg=%b/%b/%h/%h want 1/1/00/0f",
               d8_res_valid, d8_op_ready, d8_acc, d8_flags);
    end
    step();
    n_cmp++;
    if (d8_res_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL add_pulse: got rv=%b want 0", d8_res_valid);
    end
  endtask

  task automatic test_sub_cmp();
    load8(8'h05);
    issue8(OP_SUB, 8'h07);
    step();
    n_cmp++;
    if ({d8_res_valid, d8_acc, d8_flags} !== {1'b1, 8'hFE, 5'h11}) begin
      n_bad++;
      $display("FAIL sub: got rv/acc/flg=%b/%h/%h want 1/fe/11", d8_res_valid, d8_acc, d8_flags);
    end
    load8(8'h05);
    issue8(OP_CMP, 8'h05);
    step();
    n_cmp++;
    if ({d8_res_valid, d8_acc, d8_flags} !== {1'b1, 8'h05, 5'h0E}) begin
      n_bad++;
      $display("FAIL cmp: got rv/acc/flg=%b/%h/%h want 1/05/0e", d8_res_valid, d8_acc, d8_flags);
    end
  endtask

  task automatic test_daa();
    load8(8'h19);
    issue8(OP_ADD, 8'h28);
    step();
    n_cmp++;
    if ({d8_acc, d8_flags} !== {8'h41, 5'h06}) begin
      n_bad++;
      $display("FAIL daa_add1: got acc/flg=%h/%h want 41/06", d8_acc, d8_flags);
    end
    issue8(OP_DAA, 8'h00);
    step();
    n_cmp++;
    if ({d8_res_valid, d8_acc, d8_flags} !== {1'b1, 8'h47, 5'h02}) begin
      n_bad++;
      $display("FAIL daa1: got rv/acc/flg=%b/%h/%h want 1/47/02", d8_res_valid, d8_acc, d8_flags);
    end
    load8(8'h99);
    issue8(OP_ADD, 8'h01);
    step();
    n_cmp++;
    if ({d8_acc, d8_flags} !== {8'h9A, 5'h12}) begin
      n_bad++;
      $display("FAIL daa_add2: got acc/flg=%h/%h want 9a/12", d8_acc, d8_flags);
    end
    issue8(OP_DAA, 8'h00);
    step();
    n_cmp++;
    if ({d8_acc, d8_flags} !== {8'h00, 5'h0F}) begin
      n_bad++;
      $display("FAIL daa2: got acc/flg=%h/%h want 00/0f", d8_acc, d8_flags);
    end
  endtask

  task automatic test_dad();
    load8(8'h05);
    issue8(OP_CMP, 8'h05);
    step();
    d8_pair_a = 16'h80FF;
    d8_pair_b = 16'h8001;
    issue8(OP_DAD, 8'h00);
    n_cmp++;
    if ({d8_op_ready, d8_res_valid} !== 2'b00) begin
      n_bad++;
      $display("FAIL dad_lo: got rdy/rv=%b%b want 00", d8_op_ready, d8_res_valid);
    end
    step();
    n_cmp++;
    if ({d8_op_ready, d8_res_valid} !== 2'b00) begin
      n_bad++;
      $display("FAIL dad_hi: got rdy/rv=%b%b want 00", d8_op_ready, d8_res_valid);
    end
    step();
    n_cmp++;
    if ({d8_res_valid, d8_res_pair, d8_acc, d8_flags} !== {1'b1, 16'h0100, 8'h05, 5'h0F}) begin
      n_bad++;
      $display("FAIL dad_result: got rv/pair/acc/flg=%b/%h/%h/%h want 1/0100/05/0f",
               d8_res_valid, d8_res_pair, d8_acc, d8_flags);
    end
    step();
    n_cmp++;
    if ({d8_res_valid, d8_res_pair} !== {1'b0, 16'h0100}) begin
      n_bad++;
      $display("FAIL dad_hold: got rv/pair=%b/%h want 0/0100", d8_res_valid, d8_res_pair);
    end
  endtask

  task automatic test_back_to_back();
    d16_acc_wr = 1'b1; d16_acc_wdata = 16'h8001;
    d16_op_valid = 1'b1; d16_op_code = OP_RLC; d16_op_tmp = 16'h0000;
    step();
    d16_op_valid = 1'b0;
    d16_acc_wdata = 16'h1234;
    step();
    d16_acc_wr = 1'b0;
    n_cmp++;
    if ({d16_res_valid, d16_op_ready, d16_acc, d16_flags} !== {1'b1, 1'b1, 16'h0003, 5'h01}) begin
      n_bad++;
      $display("FAIL wf_rlc: got rv/rdy/acc/flg=%b/%b/%h/%h want 1/1/0003/01",
               d16_res_valid, d16_op_ready, d16_acc, d16_flags);
    end
    d16_op_valid = 1'b1; d16_op_code = OP_RRC;
    step();
    d16_op_valid = 1'b0;
    n_cmp++;
    if ({d16_op_ready, d16_res_valid} !== 2'b00) begin
      n_bad++;
      $display("FAIL b2b_accept: got rdy/rv=%b%b want 00", d16_op_ready, d16_res_valid);
    end
    step();
    n_cmp++;
    if ({d16_res_valid, d16_acc, d16_flags} !== {1'b1, 16'h8001, 5'h01}) begin
      n_bad++;
      $display("FAIL b2b_rrc: got rv/acc/flg=%b/%h/%h want 1/8001/01", d16_res_valid, d16_acc, d16_flags);
    end
    d16_op_valid = 1'b1; d16_op_code = OP_ADD; d16_op_tmp = 16'h7FFF;
    step();
    d16_op_valid = 1'b0;
    step();
    n_cmp++;
    if ({d16_res_valid, d16_acc, d16_flags} !== {1'b1, 16'h0000, 5'h0F}) begin
      n_bad++;
      $display("FAIL add16: got rv/acc/flg=%b/%h/%h want 1/0000/0f", d16_res_valid, d16_acc, d16_flags);
    end
  endtask

  task automatic test_reset_mid_dad();
    load8(8'hAA);
    d8_pair_a = 16'h1234;
    d8_pair_b = 16'h1111;
    issue8(OP_DAD, 8'h00);
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({d8_op_ready, d8_res_valid, d8_acc, d8_flags, d8_res_pair} !== {1'b1, 1'b0, 8'h00, 5'h00, 16'h0000}) begin
      n_bad++;
      $display("FAIL rst_mid_dad: got rdy/rv/acc/flg/pair=%b/%b/%h/%h/%h want 1/0/00/00/0000",
               d8_op_ready, d8_res_valid, d8_acc, d8_flags, d8_res_pair);
    end
    step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if ({d8_res_valid, d8_op_ready, d8_acc, d8_flags} !== {1'b0, 1'b1, 8'h00, 5'h00}) begin
        n_bad++;
        $display("FAIL rst_after_%0d: got rv/rdy/acc/flg=%b/%b/%h/%h want 0/1/00/00",
                 i, d8_res_valid, d8_op_ready, d8_acc, d8_flags);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_cmp();
    test_daa();
    test_dad();
    test_back_to_back();
    test_reset_mid_dad();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
